// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the five-stage pipeline
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;
endpackage

// File: rtl/hazard_pkg.sv
// hazard_pkg: hazard controller states, per-register control pair and common settings
package hazard_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} hz_state_t;
  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctl_t;
  localparam stage_ctl_t ADV  = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctl_t HOLD = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctl_t BUB  = '{en: 1'b1, flush: 1'b1};
  localparam stage_ctl_t RST_CTL = '{en: 1'b0, flush: 1'b1};
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: datapath taps into the hazard controller and its register controls.
// HAZARD_PERF_EN adds the stall/dwait/squash performance counters.
interface pipe_hazard_ctrl_if;
  import cpu_types_pkg::*;
  logic ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memtoReg_EX;
  regbits_t final_wsel_EX, rs_ID, rt_ID;
  logic uses_rt_ID, branch_taken_EX, halt_MEM;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, dwait_cnt, squash_cnt;
  modport master (
    input  ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memtoReg_EX, final_wsel_EX, rs_ID, rt_ID,
           uses_rt_ID, branch_taken_EX, halt_MEM,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halt, stall_cnt, dwait_cnt, squash_cnt
  );
  modport slave (
    output ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memtoReg_EX, final_wsel_EX, rs_ID, rt_ID,
           uses_rt_ID, branch_taken_EX, halt_MEM,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halt, stall_cnt, dwait_cnt, squash_cnt
  );
`else
  modport master (
    input  ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memtoReg_EX, final_wsel_EX, rs_ID, rt_ID,
           uses_rt_ID, branch_taken_EX, halt_MEM,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halt
  );
  modport slave (
    output ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memtoReg_EX, final_wsel_EX, rs_ID, rt_ID,
           uses_rt_ID, branch_taken_EX, halt_MEM,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halt
  );
`endif
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: load-use comparator between the EX load destination and ID sources
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     mem_to_reg,
  input  regbits_t wsel,
  input  regbits_t rs,
  input  regbits_t rt,
  input  logic     uses_rt,
  output logic     lu_hazard
);
  assign lu_hazard = mem_to_reg & (wsel != '0) & ((wsel == rs) | (uses_rt & (wsel == rt)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline register enable/flush sequencer (stalls, squashes, memory waits, halt drain).
// HAZARD_PERF_EN adds stall/dwait/squash performance counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input logic CLK,
  input logic RST,
  pipe_hazard_ctrl_if.master bus
);
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  hz_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic halt_q, lu, freeze, drain_start, ev_stall, ev_squash, ev_dwait, pc;
  stage_ctl_t ifid, idex, exmem, memwb;
  hazard_detect u_detect (
    .mem_to_reg(bus.memtoReg_EX),
    .wsel      (bus.final_wsel_EX),
    .rs        (bus.rs_ID),
    .rt        (bus.rt_ID),
    .uses_rt   (bus.uses_rt_ID),
    .lu_hazard (lu)
  );
  // DWAIT keys only on dhit; RUN needs an outstanding access to freeze
  assign freeze = (state == DWAIT) ? ~bus.dhit
                : (state == RUN) & (bus.dmemREN_MEM | bus.dmemWEN_MEM) & ~bus.dhit;
  assign drain_start = ~RST & (state == RUN) & bus.halt_MEM;
  always_comb begin
    pc = 1'b1;
    ifid = ADV;
    idex = ADV;
    exmem = ADV;
    memwb = ADV;
    nxt = state;
    ev_stall = 1'b0;
    ev_squash = 1'b0;
    ev_dwait = 1'b0;
    if (RST) begin
      pc = 1'b0;
      ifid = RST_CTL;
      idex = RST_CTL;
      exmem = RST_CTL;
      memwb = RST_CTL;
      nxt = RUN;
    end else if (state == HALTED) begin
      pc = 1'b0;
      ifid = HOLD;
      idex = HOLD;
      exmem = HOLD;
      memwb = HOLD;
    end else if (state == DRAIN || drain_start) begin
      pc = 1'b0;
      ifid = BUB;
      idex = BUB;
      exmem = BUB;
      nxt = drain_start ? DRAIN : (cnt == '0) ? HALTED : DRAIN;
    end else if (freeze) begin
      pc = 1'b0;
      ifid = HOLD;
      idex = HOLD;
      exmem = HOLD;
      memwb = HOLD;
      nxt = DWAIT;
      ev_dwait = 1'b1;
    end else begin
      nxt = RUN;
      ev_dwait = state == DWAIT;
      // a squashed ID instruction cannot stall, so the branch outranks load-use
      if (bus.branch_taken_EX) begin
        ifid = BUB;
        idex = BUB;
        ev_squash = 1'b1;
      end else if (lu) begin
        pc = 1'b0;
        ifid = HOLD;
        idex = BUB;
        ev_stall = 1'b1;
      end else if (!bus.ihit) begin
        pc = 1'b0;
        ifid = BUB;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      cnt <= '0;
      halt_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= drain_start ? CW'(DRAIN_CYCLES - 1) : (state == DRAIN && cnt != '0) ? cnt - 1'b1 : cnt;
      halt_q <= halt_q | (state == DRAIN && cnt == '0);
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.stall_cnt <= '0;
      bus.dwait_cnt <= '0;
      bus.squash_cnt <= '0;
    end else begin
      bus.stall_cnt <= bus.stall_cnt + 32'(ev_stall);
      bus.dwait_cnt <= bus.dwait_cnt + 32'(ev_dwait);
      bus.squash_cnt <= bus.squash_cnt + 32'(ev_squash);
    end
  end
`endif
  assign bus.pc_en = pc;
  assign bus.ifid_en = ifid.en;
  assign bus.ifid_flush = ifid.flush;
  assign bus.idex_en = idex.en;
  assign bus.idex_flush = idex.flush;
  assign bus.exmem_en = exmem.en;
  assign bus.exmem_flush = exmem.flush;
  assign bus.memwb_en = memwb.en;
  assign bus.memwb_flush = memwb.flush;
  assign bus.halt = halt_q & ~RST;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus multi-cycle sequences for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int pass_cnt = 0;
  int total_cnt = 0;
  // {halt, pc_en, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl}
  localparam logic [9:0] ADV    = 10'b0_1_10_10_10_10;
  localparam logic [9:0] STALL  = 10'b0_0_00_11_10_10;
  localparam logic [9:0] IBUB   = 10'b0_0_11_10_10_10;
  localparam logic [9:0] SQUASH = 10'b0_1_11_11_10_10;
  localparam logic [9:0] FREEZE = 10'b0_0_00_00_00_00;
  localparam logic [9:0] DRAINV = 10'b0_0_11_11_11_10;
  localparam logic [9:0] RSTV   = 10'b0_0_01_01_01_01;
  localparam logic [9:0] HALTV  = 10'b1_0_00_00_00_00;
  typedef struct {
    string name;
    logic ihit, dhit, ren, mtr;
    logic [4:0] w, rs, rt;
    logic urt, br;
    logic [9:0] exp;
  } vec_t;
  vec_t vq[$];
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.DRAIN_CYCLES(2)) dut (.CLK(CLK), .RST(RST), .bus(bus.master));
  always #5 CLK = ~CLK;
  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {bus.halt, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
           bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush};
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask
  task automatic idle();
    bus.ihit = 1'b1;
    bus.dhit = 1'b1;
    bus.dmemREN_MEM = 1'b0;
    bus.dmemWEN_MEM = 1'b0;
    bus.memtoReg_EX = 1'b0;
    bus.final_wsel_EX = '0;
    bus.rs_ID = '0;
    bus.rt_ID = '0;
    bus.uses_rt_ID = 1'b0;
    bus.branch_taken_EX = 1'b0;
    bus.halt_MEM = 1'b0;
  endtask
  task automatic step();
    @(negedge CLK);
  endtask
  initial begin
    vq.push_back('{"idle", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ADV});
    vq.push_back('{"lu_rs", 1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, STALL});
    vq.push_back('{"lu_r0", 1, 1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, ADV});
    vq.push_back('{"lu_rt", 1, 1, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, STALL});
    vq.push_back('{"rt_unused", 1, 1, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, ADV});
    vq.push_back('{"no_load", 1, 1, 0, 0, 5'd5, 5'd5, 5'd5, 1, 0, ADV});
    vq.push_back('{"imiss", 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, IBUB});
    vq.push_back('{"lu_imiss", 0, 1, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0, STALL});
    vq.push_back('{"br_lu_imiss", 0, 1, 0, 1, 5'd9, 5'd9, 5'd0, 0, 1, SQUASH});
    vq.push_back('{"branch", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, SQUASH});
    vq.push_back('{"load_hit", 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, ADV});
    idle();
    RST = 1'b1;
    #1;
    check("reset_comb", RSTV);
    step();
    step();
    check("reset_held", RSTV);
    RST = 1'b0;
    foreach (vq[i]) begin
      step();
      idle();
      bus.ihit = vq[i].ihit;
      bus.dhit = vq[i].dhit;
      bus.dmemREN_MEM = vq[i].ren;
      bus.memtoReg_EX = vq[i].mtr;
      bus.final_wsel_EX = vq[i].w;
      bus.rs_ID = vq[i].rs;
      bus.rt_ID = vq[i].rt;
      bus.uses_rt_ID = vq[i].urt;
      bus.branch_taken_EX = vq[i].br;
      #1;
      check(vq[i].name, vq[i].exp);
    end
    step();
    idle();
    bus.memtoReg_EX = 1'b1;
    bus.final_wsel_EX = 5'd5;
    bus.rs_ID = 5'd5;
    #1;
    check("lu_seq_stall", STALL);
    step();
    bus.memtoReg_EX = 1'b0;
    #1;
    check("lu_seq_after", ADV);
    step();
    idle();
    bus.dmemREN_MEM = 1'b1;
    bus.dhit = 1'b0;
    #1;
    check("dwait_c0", FREEZE);
    for (int i = 1; i < 3; i++) begin
      step();
      #1;
      check($sformatf("dwait_c%0d", i), FREEZE);
    end
    step();
    bus.dhit = 1'b1;
    #1;
    check("dwait_hit", ADV);
    step();
    bus.dmemREN_MEM = 1'b0;
    bus.dhit = 1'b0;
    #1;
    check("dwait_back_run", ADV);
    step();
    bus.dmemWEN_MEM = 1'b1;
    #1;
    check("store_wait", FREEZE);
    step();
    bus.dmemWEN_MEM = 1'b0;
    bus.dhit = 1'b1;
    bus.branch_taken_EX = 1'b1;
    #1;
    check("dwait_hit_branch", SQUASH);
    step();
    idle();
    bus.halt_MEM = 1'b1;
    #1;
    check("halt_run", DRAINV);
    step();
    bus.halt_MEM = 1'b0;
    bus.branch_taken_EX = 1'b1;
    bus.ihit = 1'b0;
    #1;
    check("drain_1", DRAINV);
    step();
    #1;
    check("drain_2", DRAINV);
    for (int i = 0; i < 11; i++) begin
      step();
      #1;
      check($sformatf("halted_%0d", i), HALTV);
    end
    step();
    idle();
    RST = 1'b1;
    #1;
    check("halt_reset_comb", RSTV);
    step();
    RST = 1'b0;
    #1;
    check("halt_reset_run", ADV);
    step();
    bus.dmemREN_MEM = 1'b1;
    bus.dhit = 1'b0;
    #1;
    check("rst_dwait_freeze", FREEZE);
    step();
    RST = 1'b1;
    #1;
    check("rst_dwait_comb", RSTV);
    step();
    check("rst_dwait_edge", RSTV);
    RST = 1'b0;
    bus.dmemREN_MEM = 1'b0;
    #1;
    check("rst_dwait_run", ADV);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
